// File: rtl/nibble_sub16_pkg.sv
// Shared types and defaults for the nibble-serial 16-bit subtractor.
// Optional add mode is enabled with the NIBBLE_SUB16_ADDMODE_EN macro.
package nibble_sub16_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;
    localparam int NSLICE    = DEF_WIDTH / DEF_SLICE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_sub16_sub_slice.sv
// One combinational SLICE-bit subtract (or add) step with borrow/carry.
// The op input exists only when NIBBLE_SUB16_ADDMODE_EN is defined.
module sub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
`ifdef NIBBLE_SUB16_ADDMODE_EN
    input  logic         op,
`endif
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] sum;
    logic       is_add;

`ifdef NIBBLE_SUB16_ADDMODE_EN
    assign is_add = op;
`else
    assign is_add = 1'b0;
`endif

    // Subtract is a + ~b + ~borrow; the borrow out is the inverted carry.
    always_comb begin
        sum  = '0;
        d    = '0;
        bout = 1'b0;
        if (is_add) begin
            sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, bin};
            bout = sum[W];
        end else begin
            sum  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~bin};
            bout = ~sum[W];
        end
        d = sum[W-1:0];
    end

endmodule

// File: rtl/nibble_serial_sub16.sv
// Multi-cycle WIDTH-bit subtractor, one SLICE per clock, LSB first.
// Define NIBBLE_SUB16_ADDMODE_EN to add the op port (1 = add).
module nibble_serial_sub16
    import nibble_sub16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
`ifdef NIBBLE_SUB16_ADDMODE_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             busy
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    state_t state;
    state_t state_n;

    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [WIDTH-SLICE-1:0] res_q;
    logic [WIDTH-1:0]       d_nxt;
    logic [CW-1:0]          cnt;
    logic                   brw;
    logic [SLICE-1:0]       sd;
    logic                   sb;
    logic                   addm;
    logic                   bb;
    logic                   c_in;
    logic                   c_out;
    logic                   ovf_nxt;

`ifdef NIBBLE_SUB16_ADDMODE_EN
    logic op_q;
    assign addm = op_q;
`else
    assign addm = 1'b0;
`endif

    sub_slice #(.W(SLICE)) u_slice (
        .a    (a_q[SLICE-1:0]),
        .b    (b_q[SLICE-1:0]),
        .bin  (brw),
`ifdef NIBBLE_SUB16_ADDMODE_EN
        .op   (op_q),
`endif
        .d    (sd),
        .bout (sb)
    );

    assign d_nxt = {sd, res_q};

    // Overflow = carry into the top bit XOR carry out, on the last slice.
    assign bb      = addm ? b_q[SLICE-1] : ~b_q[SLICE-1];
    assign c_in    = sd[SLICE-1] ^ a_q[SLICE-1] ^ bb;
    assign c_out   = addm ? sb : ~sb;
    assign ovf_nxt = c_in ^ c_out;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid) state_n = RUN;
            RUN:     if (cnt == LAST) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
`ifdef NIBBLE_SUB16_ADDMODE_EN
            op_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q  <= A;
                        b_q  <= B;
                        brw  <= Bin;
                        cnt  <= '0;
`ifdef NIBBLE_SUB16_ADDMODE_EN
                        op_q <= op;
`endif
                    end
                end
                RUN: begin
                    a_q   <= a_q >> SLICE;
                    b_q   <= b_q >> SLICE;
                    brw   <= sb;
                    res_q <= d_nxt[WIDTH-1:SLICE];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        D    <= d_nxt;
                        Bout <= sb;
                        zero <= (d_nxt == '0);
                        neg  <= d_nxt[WIDTH-1];
                        ovf  <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Randomized self-checking bench for nibble_serial_sub16 (subtract mode),
// compared against an integer-arithmetic reference model.
module tb_nibble_serial_sub16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        Bout;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic        busy;
`ifdef NIBBLE_SUB16_ADDMODE_EN
    logic        op;
`endif

    int passed;
    int total;

    nibble_serial_sub16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
`ifdef NIBBLE_SUB16_ADDMODE_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {D, Bout, zero, neg, ovf} from plain integer arithmetic.
    function automatic logic [19:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic bin);
        int diff;
        int sdiff;
        logic [15:0] d;
        diff  = int'(a) - int'(b) - int'(bin);
        sdiff = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d     = diff[15:0];
        return {d, diff < 0, d == 16'h0, d[15],
                (sdiff < -32768) || (sdiff > 32767)};
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input int hold,
                         output logic [19:0] got, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        A = a;
        B = b;
        Bin = bin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        Bin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = {D, Bout, zero, neg, ovf};
        repeat (hold) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] got;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        Bin = 1'b0;
`ifdef NIBBLE_SUB16_ADDMODE_EN
        op = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        got = {in_ready, out_valid, busy, D, Bout, zero, neg, ovf};
        total++;
        if (got !== {1'b1, 22'h0})
            $display("FAIL reset: got %h want %h", got, {1'b1, 22'h0});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] ta [5] = '{16'h1234, 16'h0000, 16'h8000,
                                16'h00F0, 16'hFFFF};
        logic [15:0] tb [5] = '{16'h0234, 16'h0001, 16'h0001,
                                16'h00EF, 16'h0001};
        logic        tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] td [5] = '{16'h1000, 16'hFFFF, 16'h7FFF,
                                16'h0000, 16'hFFFE};
        logic [19:0] got;
        logic [19:0] exp;
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], tc[i], 0, got, lat);
            exp = model(ta[i], tb[i], tc[i]);
            total++;
            if (got !== exp)
                $display("FAIL directed%0d: got %h want %h", i, got, exp);
            else passed++;
            total++;
            if (got[19:4] !== td[i])
                $display("FAIL directed%0d_d: got %h want %h",
                         i, got[19:4], td[i]);
            else passed++;
            total++;
            if (lat !== 4)
                $display("FAIL latency%0d: got %0d want 4", i, lat);
            else passed++;
        end
    endtask

    task automatic test_hold();
        logic [19:0] got;
        logic [19:0] exp;
        int lat;
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        A = 16'h0005;
        B = 16'h0003;
        Bin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            A = 16'($urandom);
            B = 16'($urandom);
            @(posedge clk);
            #1;
            total++;
            if ({out_valid, in_ready, D} !== {1'b1, 1'b0, 16'h0002})
                $display("FAIL hold%0d: got v=%b r=%b D=%h want v=1 r=0 D=0002",
                         i, out_valid, in_ready, D);
            else passed++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (in_ready !== 1'b0)
            $display("FAIL hs_ready: got %b want 0", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL post_hs: got %b want 100",
                     {in_ready, out_valid, busy});
        else passed++;
        do_op(16'h4321, 16'h1111, 1'b0, 0, got, lat);
        exp = model(16'h4321, 16'h1111, 1'b0);
        total++;
        if (got !== exp)
            $display("FAIL after_hold: got %h want %h", got, exp);
        else passed++;
    endtask

    task automatic test_mid_reset();
        logic [19:0] got;
        logic [19:0] exp;
        int lat;
        int seen;
        @(negedge clk);
        A = 16'h1234;
        B = 16'h0001;
        Bin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, busy, D, Bout, zero, neg, ovf}
            !== {1'b1, 22'h0})
            $display("FAIL mid_reset: got %b%b%b %h %b%b%b%b want 100 0000 0000",
                     in_ready, out_valid, busy, D, Bout, zero, neg, ovf);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0)
            $display("FAIL no_valid_after_reset: got %0d want 0", seen);
        else passed++;
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, got, lat);
        exp = model(16'hFFFF, 16'h0001, 1'b0);
        total++;
        if (got !== exp || got[19:3] !== {16'hFFFE, 1'b0})
            $display("FAIL post_reset_op: got %h want %h", got, exp);
        else passed++;
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic bin;
        logic [19:0] got;
        logic [19:0] exp;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            bin = 1'($urandom);
            if (i % 8 == 0) b = 16'h7FFF;
            if (i % 8 == 1) b = 16'h8000;
            do_op(a, b, bin, int'($urandom_range(0, 3)), got, lat);
            exp = model(a, b, bin);
            total++;
            if (got !== exp || lat !== 4)
                $display("FAIL random%0d: %h-%h-%b got %h lat %0d want %h lat 4",
                         i, a, b, bin, got, lat, exp);
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_directed();
        test_hold();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
